// File: rtl/sec_timer_if.sv
// sec_timer_if -- control and display bundle for the MM:SS stopwatch.
//   i_slow_clk : divided clock level from the upstream divider (i_clk domain)
//   i_start    : single-cycle start/resume request
//   i_stop     : single-cycle pause request
//   i_clear    : single-cycle clear request
//   o_sec_ones, o_sec_tens, o_min_ones, o_min_tens : BCD digits
//   o_running  : high while counting
//   o_rollover : one-cycle pulse after the 59:59 -> 00:00 wrap
// The master modport is the controller side; the slave modport is the timer.
interface sec_timer_if;
  logic       i_slow_clk;
  logic       i_start;
  logic       i_stop;
  logic       i_clear;
  logic [3:0] o_sec_ones;
  logic [3:0] o_sec_tens;
  logic [3:0] o_min_ones;
  logic [3:0] o_min_tens;
  logic       o_running;
  logic       o_rollover;

  modport master (
    output i_slow_clk, i_start, i_stop, i_clear,
    input  o_sec_ones, o_sec_tens, o_min_ones, o_min_tens, o_running, o_rollover
  );

  modport slave (
    input  i_slow_clk, i_start, i_stop, i_clear,
    output o_sec_ones, o_sec_tens, o_min_ones, o_min_tens, o_running, o_rollover
  );
endinterface

// File: rtl/sec_timer.sv
// sec_timer -- BCD MM:SS stopwatch advanced by rising edges of a slow level.
//   i_clk   : system clock, everything is on its rising edge
//   i_reset : synchronous, active-high
//   bus     : sec_timer_if.slave (slow level, start/stop/clear, digits, status)
// TICKS_PER_SEC (1..255) slow-clock rising edges make one second.
// A three-state FSM (IDLE/RUN/PAUSE) gates counting; the prescaler holds its
// partial count across PAUSE so a resume continues the interrupted second.
module sec_timer #(
  parameter int unsigned TICKS_PER_SEC = 1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  sec_timer_if.slave  bus
);

  localparam logic [7:0] PRE_MAX = 8'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t     r_state, w_state_nxt;
  logic       r_slow_d;
  logic [7:0] r_pre;
  logic [3:0] r_so, r_st, r_mo, r_mt;
  logic       r_running, r_rollover;
  logic       w_tick, w_count, w_sec_done, w_wrap;

  // Edge detect on the slow level; r_slow_d resets high so a level that is
  // already high at reset release is not mistaken for a fresh edge.
  assign w_tick     = bus.i_slow_clk & ~r_slow_d;
  // Clear and stop both pre-empt a tick landing in the same cycle.
  assign w_count    = w_tick & (r_state == RUN) & ~bus.i_clear & ~bus.i_stop;
  assign w_sec_done = w_count & (r_pre == PRE_MAX);
  assign w_wrap     = w_sec_done & (r_mt == 4'd5) & (r_mo == 4'd9)
                    & (r_st == 4'd5) & (r_so == 4'd9);

  // Next state: clear > stop > start. A higher-priority request that is a
  // no-op in the current state still masks the lower ones.
  always_comb begin
    w_state_nxt = r_state;
    if (bus.i_clear) begin
      w_state_nxt = IDLE;
    end else if (bus.i_stop) begin
      if (r_state == RUN) w_state_nxt = PAUSE;
    end else if (bus.i_start) begin
      if (r_state != RUN) w_state_nxt = RUN;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= IDLE;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_running <= (w_state_nxt == RUN);
    end
  end

  // Prescaler and BCD digits; each digit wraps at its own limit so no
  // out-of-range value is ever visible.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_slow_d   <= 1'b1;
      r_pre      <= 8'd0;
      r_so       <= 4'd0;
      r_st       <= 4'd0;
      r_mo       <= 4'd0;
      r_mt       <= 4'd0;
      r_rollover <= 1'b0;
    end else begin
      r_slow_d   <= bus.i_slow_clk;
      r_rollover <= w_wrap;
      if (bus.i_clear) begin
        r_pre <= 8'd0;
        r_so  <= 4'd0;
        r_st  <= 4'd0;
        r_mo  <= 4'd0;
        r_mt  <= 4'd0;
      end else if (w_sec_done) begin
        r_pre <= 8'd0;
        if (r_so == 4'd9) begin
          r_so <= 4'd0;
          if (r_st == 4'd5) begin
            r_st <= 4'd0;
            if (r_mo == 4'd9) begin
              r_mo <= 4'd0;
              r_mt <= (r_mt == 4'd5) ? 4'd0 : r_mt + 4'd1;
            end else begin
              r_mo <= r_mo + 4'd1;
            end
          end else begin
            r_st <= r_st + 4'd1;
          end
        end else begin
          r_so <= r_so + 4'd1;
        end
      end else if (w_count) begin
        r_pre <= r_pre + 8'd1;
      end
    end
  end

  assign bus.o_sec_ones = r_so;
  assign bus.o_sec_tens = r_st;
  assign bus.o_min_ones = r_mo;
  assign bus.o_min_tens = r_mt;
  assign bus.o_running  = r_running;
  assign bus.o_rollover = r_rollover;

endmodule
